btn_conditioner: RTL and testbench
==================================

# btn_conditioner

Synchronises, debounces and edge-detects the calculator's raw push-buttons (A, B, C, D, E, gen) and emits one-cycle command pulses. Sits directly upstream of `calc`: `calc` consumes `btn_pulse` instead of raw pad levels. An optional auto-repeat generates repeated pulses while a digit button is held.

## Interface
- `N_BTN`, 6, number of button channels; bit order {gen, E, D, C, B, A}, so A = bit 0.
- `DEBOUNCE_CYC`, 16, consecutive stable cycles needed to accept a level change (≥2).
- `REPEAT_DELAY`, 64, cycles from the press pulse to the first repeat pulse (≥2).
- `REPEAT_RATE`, 16, cycles between subsequent repeat pulses (≥2).
- `REPEAT_MASK`, 6'b001111, channels allowed to auto-repeat (A–D only).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  N_BTN  asynchronous button pad levels, active-high.
- `btn_level`  out  N_BTN  debounced button level.
- `btn_pulse`  out  N_BTN  one-cycle pulse per accepted press or repeat.
- `btn_repeat`  out  N_BTN  high together with `btn_pulse[i]` when that pulse is an auto-repeat.

## Operation
- Channels are fully independent; any number may pulse in the same cycle.
- Synchroniser: 2-FF chain per channel (`s1`, `s2`).
- Debounce: counter `cnt` per channel, width clog2(DEBOUNCE_CYC).
  - `s2 == btn_level`: `cnt <= 0`.
  - `s2 != btn_level` and `cnt == DEBOUNCE_CYC-1`: `btn_level <= s2`, `cnt <= 0`.
  - otherwise `cnt <= cnt+1`.
  - Any single-cycle return to the old level restarts the count.
- Press pulse: `btn_pulse[i]` is registered. It is high for exactly the cycle after the edge on which `btn_level[i]` goes 0→1. A release generates no pulse.
- Repeat FSM per channel (only if the channel's `REPEAT_MASK` bit is set):
  - States: IDLE, DELAY, RATE; counter `rcnt`.
  - IDLE → DELAY on level rise; `rcnt <= 0`.
  - DELAY: `rcnt` increments. At `rcnt == REPEAT_DELAY-1`, emit a repeat pulse, set `rcnt <= 0`, go to RATE.
  - RATE: at `rcnt == REPEAT_RATE-1`, emit a repeat pulse and set `rcnt <= 0`.
  - Any state → IDLE on the edge where `btn_level` falls. No pulse is emitted on that edge, even if the counter matches.
- `btn_repeat[i]` is set only on repeat pulses, never on the initial press pulse.

## Timing
- Reset (at the edge where `rst`=1): all outputs, `s1`, `s2`, `cnt`, `rcnt` go to 0; FSM goes to IDLE.
- Press latency: if `btn_raw[i]` is first sampled high at edge 0 and held clean, `btn_level[i]` and `btn_pulse[i]` are high after edge DEBOUNCE_CYC+1. The pulse lasts 1 cycle.
- Release latency: the same, DEBOUNCE_CYC+1 edges after the first low sample.
- Repeats: first repeat pulse REPEAT_DELAY cycles after the press pulse, then every REPEAT_RATE cycles.
- Reset mid-press: state is cleared. A button still held after `rst` drops is treated as a new press and pulses after DEBOUNCE_CYC+2 edges counted from the first non-reset edge.
- Glitch: a high of DEBOUNCE_CYC-1 or fewer sampled cycles produces no level change and no pulse.

## Configuration
- `BTN_AUTOREPEAT_EN` defined: repeat FSM present, behaving as above.
- `BTN_AUTOREPEAT_EN` undefined: repeat FSM and `rcnt` are not compiled in. `btn_repeat` is tied to 0, and each accepted press yields exactly one pulse regardless of hold time.

## Test plan
Bench parameters: DEBOUNCE_CYC=4, REPEAT_DELAY=8, REPEAT_RATE=4; `BTN_AUTOREPEAT_EN` defined unless stated.
- Clean press of A, raw high edges 0–17 → `btn_pulse[0]` after edge 5; repeats (`btn_repeat[0]`=1) after edges 13, 17 and 21; `btn_level[0]` falls after edge 23; no further pulses.
- Bounce on B: raw toggles every 2 cycles for 10 cycles, then stays high → `btn_level[1]` rises once, exactly one `btn_pulse[1]`.
- Glitch on C, raw high for 3 cycles → `btn_level[2]` stays 0, no pulse.
- Hold `gen` (bit 5, masked) for 40 cycles → exactly one pulse, `btn_repeat[5]` never set; A and D pressed on the same edge → simultaneous pulses on bits 0 and 3.
- Assert `rst` for 1 cycle while D is held in RATE → all outputs 0 after the reset edge; D pulses again 6 edges after reset release; repeats restart from DELAY.
- Build without `BTN_AUTOREPEAT_EN`, hold A for 40 cycles → one pulse only, `btn_repeat`=0 throughout.

Source files
------------

// File: rtl/btn_conditioner.sv
// Synchronises, debounces and edge-detects raw push-buttons into one-cycle command pulses.
// Optional auto-repeat for held digit buttons is compiled in when BTN_AUTOREPEAT_EN is defined.
module btn_conditioner #(
  parameter int               N_BTN        = 6,
  parameter int               DEBOUNCE_CYC = 16,
  parameter int               REPEAT_DELAY = 64,
  parameter int               REPEAT_RATE  = 16,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = 6'b001111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_repeat
);

  localparam int            CW       = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, repeat_q;
  logic [N_BTN-1:0] rise, rpt_fire;
  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];

  // A new level is accepted only after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign rise = level_d & ~level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      level_q  <= '0;
      pulse_q  <= '0;
      repeat_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q     <= btn_raw;
      s2_q     <= s1_q;
      level_q  <= level_d;
      pulse_q  <= rise | rpt_fire;
      repeat_q <= rpt_fire;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    RATE
  } rpt_state_e;

  localparam int            RMAX       = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int            RW         = $clog2(RMAX);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  rpt_state_e       state_q [N_BTN];
  rpt_state_e       state_d [N_BTN];
  logic [RW-1:0]    rcnt_q  [N_BTN];
  logic [RW-1:0]    rcnt_d  [N_BTN];
  logic [N_BTN-1:0] fall;

  assign fall = level_q & ~level_d;

  // A release always wins over a counter match, so no repeat fires on the falling edge.
  always_comb begin
    rpt_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (!REPEAT_MASK[i] || fall[i]) begin
        state_d[i] = IDLE;
        rcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          IDLE: begin
            if (rise[i]) begin
              state_d[i] = DELAY;
              rcnt_d[i]  = '0;
            end
          end
          DELAY: begin
            if (rcnt_q[i] == DELAY_LAST) begin
              rpt_fire[i] = 1'b1;
              rcnt_d[i]   = '0;
              state_d[i]  = RATE;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          RATE: begin
            if (rcnt_q[i] == RATE_LAST) begin
              rpt_fire[i] = 1'b1;
              rcnt_d[i]   = '0;
            end else begin
              rcnt_d[i] = rcnt_q[i] + RW'(1);
            end
          end
          default: begin
            state_d[i] = IDLE;
            rcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (rst) begin
        state_q[i] <= IDLE;
        rcnt_q[i]  <= '0;
      end else begin
        state_q[i] <= state_d[i];
        rcnt_q[i]  <= rcnt_d[i];
      end
    end
  end
`else
  assign rpt_fire = '0;

  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^REPEAT_MASK ^ (REPEAT_DELAY > 0) ^ (REPEAT_RATE > 0);
`endif

  assign btn_level  = level_q;
  assign btn_pulse  = pulse_q;
  assign btn_repeat = repeat_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: directed button scenarios with literal expectations, then randomized
// presses, glitches and resets checked every cycle against a sample-window behavioural model.
module tb_btn_conditioner;

  localparam int             NB   = 6;
  localparam int             DEB  = 4;
  localparam int             DLY  = 8;
  localparam int             RATE = 4;
  localparam logic [NB-1:0]  MASK = 6'b001111;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [NB-1:0] btnRaw;
  logic [NB-1:0] btnLevel;
  logic [NB-1:0] btnPulse;
  logic [NB-1:0] btnRepeat;

  int vectorsApplied = 0;
  int miscompares    = 0;

  // Behavioural model state: two-sample pipeline delay, window of recent seen samples,
  // and the number of cycles each button has been held since its press pulse.
  logic [NB-1:0] syncA, syncB;
  logic [NB-1:0] window [DEB];
  logic [NB-1:0] mLevel, mPulse, mRep;
  int            age [NB];
  bit            modelValid = 1'b0;

  int holdLeft [NB];

  btn_conditioner #(
    .N_BTN        (NB),
    .DEBOUNCE_CYC (DEB),
    .REPEAT_DELAY (DLY),
    .REPEAT_RATE  (RATE),
    .REPEAT_MASK  (MASK)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btnRaw),
    .btn_level  (btnLevel),
    .btn_pulse  (btnPulse),
    .btn_repeat (btnRepeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  // Drives inputs for the next rising edge and returns at the following falling edge.
  task automatic applyStimulus(input logic [NB-1:0] raw, input logic r);
    btnRaw = raw;
    rst    = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Level flips once every sample in the window disagrees with it; a repeat is due when
  // the hold age reaches DLY and every RATE cycles after that.
  initial begin
    logic [NB-1:0] seen;
    logic [NB-1:0] nextLevel;
    bit            flip;
    forever begin
      @(posedge clk);
      if (rst) begin
        syncA  = '0;
        syncB  = '0;
        mLevel = '0;
        mPulse = '0;
        mRep   = '0;
        for (int k = 0; k < DEB; k++) window[k] = '0;
        for (int ch = 0; ch < NB; ch++) age[ch] = 0;
        modelValid = 1'b1;
      end else begin
        seen  = syncB;
        syncB = syncA;
        syncA = btnRaw;
        for (int k = DEB - 1; k > 0; k--) window[k] = window[k-1];
        window[0] = seen;
        for (int ch = 0; ch < NB; ch++) begin
          flip = 1'b1;
          for (int k = 0; k < DEB; k++) begin
            if (window[k][ch] == mLevel[ch]) flip = 1'b0;
          end
          nextLevel[ch] = flip ? ~mLevel[ch] : mLevel[ch];
          mPulse[ch] = 1'b0;
          mRep[ch]   = 1'b0;
          if (nextLevel[ch] && !mLevel[ch]) begin
            mPulse[ch] = 1'b1;
            age[ch]    = 0;
          end else if (nextLevel[ch] && mLevel[ch]) begin
            age[ch]++;
            if (AUTO && MASK[ch] && age[ch] >= DLY && ((age[ch] - DLY) % RATE) == 0) begin
              mPulse[ch] = 1'b1;
              mRep[ch]   = 1'b1;
            end
          end
        end
        mLevel = nextLevel;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (modelValid) begin
        checkOutput("model_level", btnLevel, mLevel);
        checkOutput("model_pulse", btnPulse, mPulse);
        checkOutput("model_repeat", btnRepeat, mRep);
      end
    end
  end

  initial begin
    logic       expP;
    logic       expL;
    logic       prevLevel;
    logic [9:0] bounce;
    int         rises;
    int         presses;
    int         repeats;

    btnRaw = '0;
    rst    = 1'b1;
    @(negedge clk);
    applyStimulus('0, 1'b1);
    applyStimulus('0, 1'b1);
    checkOutput("reset_level", btnLevel, 6'b0);
    checkOutput("reset_pulse", btnPulse, 6'b0);
    checkOutput("reset_repeat", btnRepeat, 6'b0);
    repeat (5) applyStimulus('0, 1'b0);

    $display("[TB] clean press of A");
    for (int e = 0; e <= 30; e++) begin
      applyStimulus({5'b0, (e <= 17)}, 1'b0);
      expP = (e == 5) || (AUTO && (e == 13 || e == 17 || e == 21));
      checkOutput("pressA_pulse", btnPulse, {5'b0, expP});
      checkOutput("pressA_repeat", btnRepeat, {5'b0, expP && (e != 5)});
      checkOutput("pressA_level", btnLevel, {5'b0, (e >= 5 && e <= 22)});
    end
    repeat (5) applyStimulus('0, 1'b0);

    $display("[TB] bouncing B");
    bounce    = 10'b1100110011;
    rises     = 0;
    presses   = 0;
    prevLevel = 1'b0;
    for (int e = 0; e < 40; e++) begin
      applyStimulus({4'b0, (e < 10) ? bounce[e] : (e < 25), 1'b0}, 1'b0);
      if (btnLevel[1] && !prevLevel) rises++;
      if (btnPulse[1] && !btnRepeat[1]) presses++;
      prevLevel = btnLevel[1];
    end
    checkOutput("bounceB_levelRises", rises, 1);
    checkOutput("bounceB_presses", presses, 1);
    repeat (5) applyStimulus('0, 1'b0);

    $display("[TB] short glitch on C");
    for (int e = 0; e < 15; e++) begin
      applyStimulus({3'b0, (e < 3), 2'b0}, 1'b0);
      checkOutput("glitchC_level", btnLevel, 6'b0);
      checkOutput("glitchC_pulse", btnPulse, 6'b0);
    end

    $display("[TB] hold gen");
    presses = 0;
    repeats = 0;
    for (int e = 0; e < 50; e++) begin
      applyStimulus({(e < 40), 5'b0}, 1'b0);
      if (btnPulse[5]) presses++;
      if (btnRepeat[5]) repeats++;
    end
    checkOutput("holdGen_pulses", presses, 1);
    checkOutput("holdGen_repeats", repeats, 0);
    repeat (5) applyStimulus('0, 1'b0);

    $display("[TB] A and D together");
    for (int e = 0; e <= 10; e++) begin
      applyStimulus(6'b001001, 1'b0);
      checkOutput("pressAD_pulse", btnPulse, (e == 5) ? 6'b001001 : 6'b000000);
    end
    repeat (30) applyStimulus('0, 1'b0);

    $display("[TB] reset while D repeats");
    for (int e = 0; e <= 44; e++) begin
      applyStimulus((e <= 36) ? 6'b001000 : 6'b000000, (e == 16));
      expP = (e == 5) || (e == 22) || (AUTO && (e == 13 || e == 30 || e == 34 || e == 38));
      expL = (e >= 5 && e <= 15) || (e >= 22 && e <= 41);
      checkOutput("resetD_pulse", btnPulse, {2'b0, expP, 3'b0});
      checkOutput("resetD_repeat", btnRepeat, {2'b0, expP && (e != 5) && (e != 22), 3'b0});
      checkOutput("resetD_level", btnLevel, {2'b0, expL, 3'b0});
    end
    repeat (5) applyStimulus('0, 1'b0);

    $display("[TB] randomized presses");
    for (int ch = 0; ch < NB; ch++) holdLeft[ch] = 0;
    for (int c = 0; c < 1500; c++) begin
      logic [NB-1:0] raw;
      raw = btnRaw;
      for (int ch = 0; ch < NB; ch++) begin
        if (holdLeft[ch] == 0) begin
          raw[ch]      = 1'($urandom_range(0, 1));
          holdLeft[ch] = int'($urandom_range(1, 30));
        end else begin
          holdLeft[ch]--;
        end
      end
      applyStimulus(raw, ($urandom_range(0, 299) == 0));
    end
    repeat (3) applyStimulus('0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
